// File: rtl/jpeg_arb_pkg.sv
// Shared types for the jpeg_core input-port arbiter: FSM state encoding and
// the bitstream word/strobe widths.
package jpeg_arb_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/jpeg_arb_rr_pick.sv
// Rotating-priority encoder: returns the first asserted request at or after
// ptr_i, wrapping at NUM_SRC, plus an any-request flag.
module jpeg_arb_rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [IDW-1:0]     winner_o,
  output logic               any_o
);

  logic [2*NUM_SRC-1:0] req2;
  logic [NUM_SRC-1:0]   rot;
  logic [IDW:0]         sel_idx [NUM_SRC];
  logic [IDW-1:0]       off;
  logic [IDW:0]         sum;

  // Doubling the request vector lets a plain index stand in for the modulo rotate.
  assign req2 = {req_i, req_i};

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_rot
    assign sel_idx[gi] = {1'b0, ptr_i} + (IDW+1)'(gi);
    assign rot[gi]     = req2[sel_idx[gi]];
  end

  always_comb begin
    off = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (rot[i]) off = i[IDW-1:0];
    end
  end

  assign sum      = {1'b0, ptr_i} + {1'b0, off};
  assign winner_o = (sum >= (IDW+1)'(NUM_SRC)) ? (sum[IDW-1:0] - IDW'(NUM_SRC)) : sum[IDW-1:0];
  assign any_o    = |req_i;

endmodule

// File: rtl/jpeg_stream_arbiter.sv
// Image-atomic round-robin arbiter in front of jpeg_core's input port.
// Optional DRAIN watchdog enabled by defining JPEG_ARB_WDOG_EN.
module jpeg_stream_arbiter
  import jpeg_arb_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int IDW         = 2,
  parameter int IDLE_HOLD   = 4,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_SRC-1:0]        src_valid_i,
  input  logic [NUM_SRC*WORD_W-1:0] src_data_i,
  input  logic [NUM_SRC*STRB_W-1:0] src_strb_i,
  input  logic [NUM_SRC-1:0]        src_last_i,
  output logic [NUM_SRC-1:0]        src_accept_o,
  output logic                      dec_valid_o,
  output logic [WORD_W-1:0]         dec_data_o,
  output logic [STRB_W-1:0]         dec_strb_o,
  output logic                      dec_last_o,
  input  logic                      dec_accept_i,
  input  logic                      dec_idle_i,
  output logic                      owner_valid_o,
  output logic [IDW-1:0]            owner_id_o,
  output logic                      done_o,
  output logic [IDW-1:0]            done_id_o,
  output logic                      err_o
);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] done_id_q, done_id_d;
  logic [3:0]     hold_cnt_q, hold_cnt_d;
  logic           done_q, done_d;

  logic [IDW-1:0]    pick_id;
  logic              pick_any;
  logic              granted;
  logic              beat_last;
  logic              wdog_trip;
  logic [WORD_W-1:0] data_arr [NUM_SRC];
  logic [STRB_W-1:0] strb_arr [NUM_SRC];

  jpeg_arb_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDW     (IDW)
  ) u_pick (
    .req_i    (src_valid_i),
    .ptr_i    (rr_ptr_q),
    .winner_o (pick_id),
    .any_o    (pick_any)
  );

  assign granted = (state_q == ARB_GRANT);

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign data_arr[gi]     = src_data_i[gi*WORD_W +: WORD_W];
    assign strb_arr[gi]     = src_strb_i[gi*STRB_W +: STRB_W];
    assign src_accept_o[gi] = granted && (owner_q == IDW'(gi)) && dec_accept_i;
  end

  // Valid is never gated by accept, so the decoder sees a clean valid/accept handshake.
  assign dec_valid_o = granted && src_valid_i[owner_q];
  assign dec_data_o  = granted ? data_arr[owner_q] : '0;
  assign dec_strb_o  = granted ? strb_arr[owner_q] : '0;
  assign dec_last_o  = granted && src_last_i[owner_q];
  assign beat_last   = dec_valid_o && dec_accept_i && dec_last_o;

`ifdef JPEG_ARB_WDOG_EN
  logic [11:0] wdog_cnt_q, wdog_cnt_d;
  logic        err_q, err_d;

  assign wdog_trip = (state_q == ARB_DRAIN) && (wdog_cnt_q == 12'(WDOG_CYCLES - 1));

  always_comb begin
    wdog_cnt_d = (state_q == ARB_DRAIN) ? (wdog_cnt_q + 12'd1) : '0;
    err_d      = err_q | wdog_trip;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdog_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign wdog_trip = (WDOG_CYCLES < 0);
  assign err_o     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    done_id_d  = done_id_q;
    hold_cnt_d = '0;
    done_d     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d  = ARB_GRANT;
          owner_d  = pick_id;
          rr_ptr_d = (int'(pick_id) == NUM_SRC - 1) ? '0 : (pick_id + 1'b1);
        end
      end
      ARB_GRANT: begin
        if (beat_last) state_d = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        hold_cnt_d = dec_idle_i ? (hold_cnt_q + 4'd1) : '0;
        if ((dec_idle_i && (hold_cnt_q == 4'(IDLE_HOLD - 1))) || wdog_trip) begin
          state_d    = ARB_IDLE;
          hold_cnt_d = '0;
          done_d     = 1'b1;
          done_id_d  = owner_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      done_id_q  <= '0;
      hold_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      done_id_q  <= done_id_d;
      hold_cnt_q <= hold_cnt_d;
      done_q     <= done_d;
    end
  end

  assign owner_valid_o = (state_q == ARB_GRANT) || (state_q == ARB_DRAIN);
  assign owner_id_o    = owner_q;
  assign done_o        = done_q;
  assign done_id_o     = done_id_q;

endmodule

// File: tb/tb_jpeg_stream_arbiter.sv
// Directed bench for jpeg_stream_arbiter; the watchdog case adapts to JPEG_ARB_WDOG_EN.
module tb_jpeg_stream_arbiter;

  localparam int NUM_SRC     = 4;
  localparam int IDW         = 2;
  localparam int IDLE_HOLD   = 4;
  localparam int WDOG_CYCLES = 16;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [NUM_SRC-1:0]     src_valid_i;
  logic [NUM_SRC*32-1:0]  src_data_i;
  logic [NUM_SRC*4-1:0]   src_strb_i;
  logic [NUM_SRC-1:0]     src_last_i;
  logic [NUM_SRC-1:0]     src_accept_o;
  logic                   dec_valid_o;
  logic [31:0]            dec_data_o;
  logic [3:0]             dec_strb_o;
  logic                   dec_last_o;
  logic                   dec_accept_i;
  logic                   dec_idle_i;
  logic                   owner_valid_o;
  logic [IDW-1:0]         owner_id_o;
  logic                   done_o;
  logic [IDW-1:0]         done_id_o;
  logic                   err_o;

  int checks = 0;
  int errors = 0;
  int exp_id;
  logic [6:0] idle_pat;

  jpeg_stream_arbiter #(
    .NUM_SRC     (NUM_SRC),
    .IDW         (IDW),
    .IDLE_HOLD   (IDLE_HOLD),
    .WDOG_CYCLES (WDOG_CYCLES)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .src_valid_i   (src_valid_i),
    .src_data_i    (src_data_i),
    .src_strb_i    (src_strb_i),
    .src_last_i    (src_last_i),
    .src_accept_o  (src_accept_o),
    .dec_valid_o   (dec_valid_o),
    .dec_data_o    (dec_data_o),
    .dec_strb_o    (dec_strb_o),
    .dec_last_o    (dec_last_o),
    .dec_accept_i  (dec_accept_i),
    .dec_idle_i    (dec_idle_i),
    .owner_valid_o (owner_valid_o),
    .owner_id_o    (owner_id_o),
    .done_o        (done_o),
    .done_id_o     (done_id_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_word(input int k, input logic [31:0] d, input logic l);
    src_data_i[k*32 +: 32] = d;
    src_last_i[k]          = l;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; src_valid_i = '0; src_last_i = '0; src_data_i = '0;
    src_strb_i = 16'h8421; dec_accept_i = 1'b1; dec_idle_i = 1'b1;
    step(); step();
    check_val("rst_owner_valid", owner_valid_o, 0);
    check_val("rst_owner_id", owner_id_o, 0);
    check_val("rst_done", done_o, 0);
    check_val("rst_err", err_o, 0);
    check_val("rst_dec_valid", dec_valid_o, 0);
    check_val("rst_accept", src_accept_o, 0);

    // 1: source 1 alone, three words, decoder busy one cycle then idle
    rst_i = 1'b0; src_valid_i = 4'b0010; set_word(1, 32'hA1, 1'b0); settle();
    check_val("t1_idle_owner", owner_valid_o, 0);
    check_val("t1_idle_accept", src_accept_o, 0);
    step();
    check_val("t1_owner_valid", owner_valid_o, 1);
    check_val("t1_owner_id", owner_id_o, 1);
    check_val("t1_w0", dec_data_o, 32'hA1);
    check_val("t1_strb", dec_strb_o, 4'h2);
    check_val("t1_accept", src_accept_o, 4'b0010);
    step(); set_word(1, 32'hA2, 1'b0); settle();
    check_val("t1_w1", dec_data_o, 32'hA2);
    step(); set_word(1, 32'hA3, 1'b1); settle();
    check_val("t1_w2", dec_data_o, 32'hA3);
    check_val("t1_last", dec_last_o, 1);
    step(); src_valid_i = '0; src_last_i = '0; dec_idle_i = 1'b0; settle();
    check_val("t1_drain_valid", dec_valid_o, 0);
    check_val("t1_drain_owner", owner_valid_o, 1);
    step(); dec_idle_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("t1_nodone", done_o, 0);
    end
    step();
    check_val("t1_done", done_o, 1);
    check_val("t1_done_id", done_id_o, 1);
    check_val("t1_idle_after", owner_valid_o, 0);
    check_val("t1_owner_hold", owner_id_o, 1);
    $display("image done owner=%0d", done_id_o);
    step();
    check_val("t1_done_pulse", done_o, 0);

    // 2: all four valid with single-beat images, starting from rr_ptr=0
    rst_i = 1'b1; step(); rst_i = 1'b0;
    src_valid_i = 4'b1111;
    for (int k = 0; k < NUM_SRC; k++) set_word(k, 32'hB0 + k, 1'b1);
    step();
    for (int k = 0; k < 5; k++) begin
      exp_id = k % NUM_SRC;
      check_val("t2_owner", owner_id_o, exp_id);
      check_val("t2_data", dec_data_o, 32'hB0 + exp_id);
      check_val("t2_accept", src_accept_o, 1 << exp_id);
      $display("grant owner=%0d data=%0h", owner_id_o, dec_data_o);
      step();
      check_val("t2_drain", dec_valid_o, 0);
      step(); step(); step();
      check_val("t2_nodone", done_o, 0);
      step();
      check_val("t2_done", done_o, 1);
      check_val("t2_done_id", done_id_o, exp_id);
      if (k == 4) src_valid_i = '0;
      step();
    end

    // 3: owner 2 stalls mid-image while source 0 waits
    src_valid_i = 4'b0101; src_last_i = '0;
    set_word(2, 32'hC0, 1'b0); set_word(0, 32'hD0, 1'b0); settle();
    step();
    check_val("t3_owner", owner_id_o, 2);
    check_val("t3_w0", dec_data_o, 32'hC0);
    step(); src_valid_i = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      settle();
      check_val("t3_hold_valid", dec_valid_o, 0);
      check_val("t3_no_accept0", src_accept_o[0], 0);
      check_val("t3_owner_hold", owner_id_o, 2);
      step();
    end
    src_valid_i = 4'b0101; set_word(2, 32'hC1, 1'b1); settle();
    check_val("t3_w1", dec_data_o, 32'hC1);
    step(); src_valid_i = 4'b0001; src_last_i[2] = 1'b0;
    step(); step(); step(); step();
    check_val("t3_done", done_o, 1);
    check_val("t3_done_id", done_id_o, 2);
    step();

    // 4: source 0 image with decoder accept 1,0,1
    check_val("t4_owner", owner_id_o, 0);
    check_val("t4_w0", dec_data_o, 32'hD0);
    step(); set_word(0, 32'hD1, 1'b1); dec_accept_i = 1'b0; settle();
    check_val("t4_w1", dec_data_o, 32'hD1);
    check_val("t4_stall_accept", src_accept_o, 0);
    check_val("t4_stall_valid", dec_valid_o, 1);
    step(); dec_accept_i = 1'b1; settle();
    check_val("t4_w1_hold", dec_data_o, 32'hD1);
    check_val("t4_last", dec_last_o, 1);
    check_val("t4_accept", src_accept_o, 4'b0001);
    step(); src_valid_i = '0; src_last_i = '0; settle();
    check_val("t4_drain", owner_valid_o, 1);

    // 5: idle pattern 1,1,0,1,1,1,1 in DRAIN
    idle_pat = 7'b1111011;
    for (int i = 0; i < 7; i++) begin
      dec_idle_i = idle_pat[i];
      step();
      check_val("t5_done", done_o, (i == 6));
    end
    check_val("t5_done_id", done_id_o, 0);

    // 6: decoder never goes idle after a single-beat image from source 3
    src_valid_i = 4'b1000; set_word(3, 32'hF3, 1'b1); settle();
    step();
    check_val("t6_owner", owner_id_o, 3);
    step(); src_valid_i = '0; src_last_i = '0; dec_idle_i = 1'b0;
    for (int i = 0; i < WDOG_CYCLES - 1; i++) begin
      step();
      check_val("t6_pre_err", err_o, 0);
      check_val("t6_pre_drain", owner_valid_o, 1);
    end
    step();
`ifdef JPEG_ARB_WDOG_EN
    check_val("t6_err", err_o, 1);
    check_val("t6_done", done_o, 1);
    check_val("t6_idle", owner_valid_o, 0);
    step();
    check_val("t6_err_sticky", err_o, 1);
`else
    check_val("t6_err", err_o, 0);
    check_val("t6_stay_drain", owner_valid_o, 1);
    dec_idle_i = 1'b1;
    step(); step(); step(); step();
    check_val("t6_done", done_o, 1);
    check_val("t6_done_id", done_id_o, 3);
`endif
    dec_idle_i = 1'b1;

    // 7: reset pulse while source 1 holds the grant
    src_valid_i = 4'b0010; set_word(1, 32'hE0, 1'b0); settle();
    step();
    check_val("t7_grant", owner_valid_o, 1);
    check_val("t7_grant_id", owner_id_o, 1);
    rst_i = 1'b1;
    step();
    check_val("t7_owner_valid", owner_valid_o, 0);
    check_val("t7_dec_valid", dec_valid_o, 0);
    check_val("t7_owner_id", owner_id_o, 0);
    check_val("t7_accept", src_accept_o, 0);
    check_val("t7_err", err_o, 0);
    rst_i = 1'b0; src_valid_i = 4'b1111; src_last_i = '0; settle();
    step();
    check_val("t7_rr_ptr", owner_id_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
